// File: rtl/apb_pkg.sv
// Shared types for the APB command master: FSM state encoding, buffered command
// format and default bus widths.
`timescale 1ns/1ps
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  // Stored at the package widths; narrower top-level widths are zero-extended.
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one wrap bit so full and empty are
// told apart without a separate counter.
`timescale 1ns/1ps
module apb_cmd_fifo
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  apb_cmd_t push_data_i,
  input  logic     pop_i,
  output apb_cmd_t pop_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  apb_cmd_t    mem_q [DEPTH];

  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: state registers use <= so every flop samples pre-edge values,
  // independent of the order in which blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: buffered commands run one at a time as SETUP/ACCESS transfers.
// Define APB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYCLES wait cycles.
`timescale 1ns/1ps
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              P_clk,
  input  logic              P_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic [ADDR_W-1:0] P_addr,
  output logic              P_selx,
  output logic              P_enable,
  output logic              P_write,
  output logic [DATA_W-1:0] P_wdata,
  input  logic              P_ready,
  input  logic              P_slverr,
  input  logic [DATA_W-1:0] P_rdata
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic              pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
  logic              rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic              fifo_full, fifo_empty, pop, timeout;
  apb_cmd_t          push_cmd, head_cmd;

  assign push_cmd.write = req_write;
  assign push_cmd.addr  = APB_ADDR_W'(req_addr);
  assign push_cmd.wdata = APB_DATA_W'(req_wdata);
  assign req_ready      = !fifo_full;

  apb_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk         (P_clk),
    .rst_n       (P_rst_n),
    .push_i      (req_valid),
    .push_data_i (push_cmd),
    .pop_i       (pop),
    .pop_data_o  (head_cmd),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Expiry is flagged in the wait cycle whose increment reaches the limit.
  assign timeout = (state_q == ACCESS) && !P_ready &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == SETUP)                    to_cnt_d = '0;
    else if (state_q == ACCESS && !P_ready)  to_cnt_d = to_cnt_q + TO_ONE;
  end

  always_ff @(posedge P_clk or negedge P_rst_n) begin
    if (!P_rst_n) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
`else
  // Parameter kept for a uniform interface; it has no effect without the counter.
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a hold default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    pop       = 1'b0;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !rvalid_q) begin
          pop       = 1'b1;
          paddr_d   = ADDR_W'(head_cmd.addr);
          pwrite_d  = head_cmd.write;
          pwdata_d  = DATA_W'(head_cmd.wdata);
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (P_ready || timeout) begin
          // A completing slave beats a simultaneous expiry.
          rdata_d   = (P_ready && !pwrite_q) ? P_rdata : '0;
          rerr_d    = P_ready ? P_slverr : 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge P_clk or negedge P_rst_n) begin
    if (!P_rst_n) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
    end
  end

  assign P_addr     = paddr_q;
  assign P_write    = pwrite_q;
  assign P_wdata    = pwdata_q;
  assign P_selx     = psel_q;
  assign P_enable   = penable_q;
  assign rsp_valid  = rvalid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_slverr = rerr_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a transaction-level model and an APB
// slave model; define APB_TIMEOUT_EN to exercise the bounded ACCESS phase.
`timescale 1ns/1ps
module tb_apb_cmd_master;

  localparam int TO = 16;

  logic        P_clk = 1'b0;
  logic        P_rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_slverr;
  logic [31:0] rsp_rdata;
  logic [31:0] P_addr, P_wdata, P_rdata;
  logic        P_selx, P_enable, P_write, P_ready, P_slverr;

  always #5 P_clk = ~P_clk;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .P_clk      (P_clk),
    .P_rst_n    (P_rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .P_addr     (P_addr),
    .P_selx     (P_selx),
    .P_enable   (P_enable),
    .P_write    (P_write),
    .P_wdata    (P_wdata),
    .P_ready    (P_ready),
    .P_slverr   (P_slverr),
    .P_rdata    (P_rdata)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always @(posedge P_clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave behaviour: read data and error are pure functions of the address.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h8) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic err_fn(input logic [31:0] a);
    return a[8];
  endfunction

  int wait_states = 0;
  bit hang        = 1'b0;
  int acc_cyc     = 0;

  always @(negedge P_clk) begin
    if (P_selx && P_enable) begin
      P_ready  = !hang && (acc_cyc >= wait_states);
      P_rdata  = P_ready ? rd_fn(P_addr) : 32'hBAD0_0000 | 32'(cyc);
      P_slverr = P_ready ? err_fn(P_addr) : cyc[0];
      acc_cyc++;
    end else begin
      P_ready  = 1'b0;
      P_rdata  = $urandom;
      P_slverr = cyc[0];
      acc_cyc  = 0;
    end
  end

  // Transaction model: accepted commands in order, the one on the bus, and the
  // response owed for it.
  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_s;

  cmd_s        cmd_q[$];
  cmd_s        cur;
  bit          in_flight = 1'b0, resp_pending = 1'b0, last_ready = 1'b0;
  int          acc_n = 0, rsp_count = 0, setup_gap = 0, last_setup = 0;
  logic [31:0] exp_rdata;
  logic        exp_err;

  always @(negedge P_clk) begin
    #3;
    if (!P_rst_n) begin
      check("rst_selx", P_selx, 0);
      check("rst_enable", P_enable, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_addr", P_addr, 0);
      check("rst_rdata", rsp_rdata, 0);
      cmd_q.delete();
      in_flight    = 1'b0;
      resp_pending = 1'b0;
    end else begin
      if (P_selx && !in_flight) begin
        check("setup_enable", P_enable, 0);
        check("setup_has_cmd", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0) cur = cmd_q.pop_front();
        setup_gap  = cyc - last_setup;
        last_setup = cyc;
        in_flight  = 1'b1;
        acc_n      = 0;
        last_ready = 1'b0;
      end else if (P_selx) begin
        check("access_enable", P_enable, 1);
        acc_n++;
        last_ready = P_ready;
      end
      if (P_selx) begin
        check("bus_addr", P_addr, cur.a);
        check("bus_write", P_write, cur.w);
        check("bus_wdata", P_wdata, cur.d);
      end else begin
        check("enable_without_sel", P_enable, 0);
        if (in_flight) begin
          in_flight = 1'b0;
          if (last_ready) begin
            exp_rdata = cur.w ? 32'h0 : rd_fn(cur.a);
            exp_err   = err_fn(cur.a);
          end else begin
`ifdef APB_TIMEOUT_EN
            check("timeout_length", acc_n, TO);
`else
            check("end_without_ready", last_ready, 1);
`endif
            exp_rdata = 32'h0;
            exp_err   = 1'b1;
          end
          resp_pending = 1'b1;
        end
      end
      if (resp_pending) begin
        check("rsp_valid", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_slverr", rsp_slverr, exp_err);
        if (rsp_ready) begin
          resp_pending = 1'b0;
          rsp_count++;
        end
      end else begin
        check("rsp_idle", rsp_valid, 0);
      end
    end
  end

  task automatic step();
    @(negedge P_clk);
    #1;
  endtask

  task automatic push(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int budget, output bit ok);
    cmd_s c;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (req_ready) begin
        c.w = w; c.a = a; c.d = d;
        cmd_q.push_back(c);
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget, input string name);
    for (int i = 0; i < budget && rsp_count < target; i++) step();
    check(name, rsp_count, target);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int en_cnt, base;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    P_rst_n   = 1'b1;
    #2 P_rst_n = 1'b0;
    repeat (3) step();
    check("reset_req_ready", req_ready, 1);
    check("reset_selx", P_selx, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    P_rst_n = 1'b1;
    step();

    // Zero-wait write: SETUP after N+1, ACCESS after N+2, response after N+3.
    push(1'b1, 32'h4, 32'h5, 0, ok);
    check("t1_accept", ok, 1);
    check("t1_selx_N", P_selx, 0);
    step();
    check("t1_selx_N1", P_selx, 1);
    check("t1_enable_N1", P_enable, 0);
    check("t1_addr", P_addr, 32'h4);
    check("t1_wdata", P_wdata, 32'h5);
    step();
    check("t1_enable_N2", P_enable, 1);
    step();
    check("t1_rsp_valid_N3", rsp_valid, 1);
    check("t1_rsp_rdata", rsp_rdata, 0);
    check("t1_rsp_slverr", rsp_slverr, 0);
    check("t1_selx_N3", P_selx, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t1_rsp_cleared", rsp_valid, 0);

    // Read with two wait states.
    wait_states = 2;
    push(1'b0, 32'h8, 32'h1234, 0, ok);
    step();
    check("t2_setup_addr", P_addr, 32'h8);
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (P_enable) begin
        en_cnt++;
        check("t2_addr_stable", P_addr, 32'h8);
      end
    end
    check("t2_enable_cycles", en_cnt, 3);
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rdata", rsp_rdata, 32'hDEAD_BEEF);
    rsp_ready = 1'b1;
    step();

    // Back-to-back mix with a slave error; transfers start every 4 cycles.
    wait_states = 0;
    base = rsp_count;
    push(1'b0, 32'h100, 32'h0, 0, ok);
    push(1'b1, 32'h10, 32'hCAFE, 0, ok);
    push(1'b0, 32'h20, 32'h0, 0, ok);
    wait_rsp(base + 3, 40, "t3_rsp_count");
    check("t3_setup_gap", setup_gap, 4);

    // Backpressure: one in flight plus four queued, the sixth is refused.
    rsp_ready = 1'b0;
    step();
    base = rsp_count;
    for (int i = 0; i < 5; i++) begin
      push(i[0], 32'h40 + 32'(i * 4), 32'h1000 + 32'(i), 0, ok);
      check("t4_accept", ok, 1);
    end
    check("t4_full", req_ready, 0);
    push(1'b1, 32'h60, 32'h6666, 4, ok);
    check("t4_sixth_blocked", ok, 0);
    rsp_ready = 1'b1;
    push(1'b1, 32'h60, 32'h6666, 40, ok);
    check("t4_sixth_accept", ok, 1);
    wait_rsp(base + 6, 60, "t4_rsp_count");

    // Slave never ready.
    rsp_ready = 1'b0;
    hang      = 1'b1;
    step();
    push(1'b0, 32'hC, 32'h0, 0, ok);
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 40 && !rsp_valid; i++) step();
    check("t5_timeout_rsp", rsp_valid, 1);
    check("t5_timeout_slverr", rsp_slverr, 1);
    check("t5_timeout_selx", P_selx, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    push(1'b0, 32'hC, 32'h0, 0, ok);
    step();
    step();
`else
    step();
    en_cnt = 0;
    for (int i = 0; i < 110; i++) begin
      step();
      if (P_enable) en_cnt++;
    end
    check("t5_enable_held", en_cnt, 110);
    check("t5_no_rsp", rsp_valid, 0);
`endif

    // Reset in the middle of ACCESS, with a further command queued.
    push(1'b1, 32'h30, 32'h3030, 0, ok);
    check("t6_in_access", P_enable, 1);
    P_rst_n = 1'b0;
    #1;
    check("t6_selx_async", P_selx, 0);
    check("t6_enable_async", P_enable, 0);
    check("t6_req_ready_async", req_ready, 1);
    step();
    step();
    P_rst_n = 1'b1;
    hang    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t6_no_rsp", rsp_valid, 0);
      check("t6_no_transfer", P_selx, 0);
    end
    check("t6_req_ready", req_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
